// File: rtl/inj_pkg.sv
// Shared definitions for the injection scheduler: flit width, FSM state codes,
// flit field positions and the source-index width helper.
package inj_pkg;

  localparam int unsigned FLIT_W = 20;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_GRANT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int unsigned DEST_LSB    = 0;
  localparam int unsigned DEST_MSB    = 1;
  localparam int unsigned PAYLOAD_LSB = 4;
  localparam int unsigned PAYLOAD_MSB = 19;

  function automatic int unsigned src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inj_skid_fifo.sv
// Small circular skid FIFO with occupancy count; a push into a full FIFO is
// still accepted when a pop happens in the same cycle.
module inj_skid_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count < CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      end
      if (w_do_pop) r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/inj_sched.sv
// Round-robin injection scheduler feeding a skid FIFO toward one router port.
// Optional protocol checker on err is built when INJ_SCHED_CHECK_EN is defined.
module inj_sched import inj_pkg::*; #(
  parameter int unsigned N_SRC         = 4,
  parameter int unsigned FLIT_W        = inj_pkg::FLIT_W,
  parameter int unsigned QUANTUM       = 4,
  parameter int unsigned WORDS_PER_SRC = 30,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_SRC-1:0]          src_mask,
  output logic [N_SRC-1:0]          src_enable,
  input  logic [N_SRC*FLIT_W-1:0]   src_data,
  input  logic [N_SRC-1:0]          src_valid,
  output logic [FLIT_W-1:0]         out_flit,
  output logic [src_w(N_SRC)-1:0]   out_src,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      all_done,
  output logic                      err
);

  localparam int unsigned SW = src_w(N_SRC);
  localparam int unsigned IW = $clog2(WORDS_PER_SRC + 1);
  localparam int unsigned QW = $clog2(QUANTUM + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = SW + FLIT_W;

  logic [2:0]                   r_state, w_state_nxt;
  logic [N_SRC-1:0]             r_mask, w_mask_nxt;
  logic [N_SRC-1:0]             r_primed, w_primed_nxt;
  logic [N_SRC-1:0][IW-1:0]     r_issued, w_issued_nxt;
  logic [SW-1:0]                r_rr, w_rr_nxt;
  logic [SW-1:0]                r_g_idx, w_g_idx_nxt;
  logic [QW-1:0]                r_q_cnt, w_q_cnt_nxt;
  logic                         r_pend, w_pend_nxt;
  logic [N_SRC-1:0]             w_enable;
  logic [N_SRC-1:0]             w_exh, w_exh_start;
  logic                         w_found;
  int                           w_j;
  logic                         w_room;
  logic                         w_push, w_pop, w_fifo_valid;
  logic [EW-1:0]                w_push_data, w_head;
  logic [CW-1:0]                w_fifo_count;

  // A source is exhausted when masked off or all its words have been requested.
  always_comb begin
    for (int i = 0; i < int'(N_SRC); i++) begin
      w_exh[i]       = ~r_mask[i]   | (r_issued[i] == IW'(WORDS_PER_SRC));
      w_exh_start[i] = ~src_mask[i] | (r_issued[i] == IW'(WORDS_PER_SRC));
    end
  end

  // Enable only when the FIFO can absorb the in-flight flit plus the new one.
  assign w_room = (({1'b0, w_fifo_count} + (CW+1)'(r_pend)) < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    w_state_nxt  = r_state;
    w_mask_nxt   = r_mask;
    w_primed_nxt = r_primed;
    w_issued_nxt = r_issued;
    w_rr_nxt     = r_rr;
    w_g_idx_nxt  = r_g_idx;
    w_q_cnt_nxt  = r_q_cnt;
    w_pend_nxt   = 1'b0;
    w_enable     = '0;
    w_found      = 1'b0;
    w_j          = 0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_mask_nxt  = src_mask;
          w_state_nxt = (&w_exh_start) ? S_DONE : S_ARB;
        end
      end
      S_ARB: begin
        w_q_cnt_nxt = '0;
        w_state_nxt = S_FLUSH;
        for (int k = 0; k < int'(N_SRC); k++) begin
          w_j = (int'(r_rr) + k) % int'(N_SRC);
          if (!w_found && !w_exh[SW'(w_j)]) begin
            w_found     = 1'b1;
            w_g_idx_nxt = SW'(w_j);
            w_state_nxt = S_GRANT;
          end
        end
      end
      S_GRANT: begin
        if (w_room) begin
          w_enable[r_g_idx] = 1'b1;
          w_pend_nxt        = r_primed[r_g_idx];
          if (!r_primed[r_g_idx]) begin
            w_primed_nxt[r_g_idx] = 1'b1;
          end else begin
            w_issued_nxt[r_g_idx] = r_issued[r_g_idx] + IW'(1);
            w_q_cnt_nxt           = r_q_cnt + QW'(1);
            if ((r_q_cnt == QW'(QUANTUM - 1)) ||
                (r_issued[r_g_idx] == IW'(WORDS_PER_SRC - 1)))
              w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_rr_nxt    = (r_g_idx == SW'(N_SRC - 1)) ? '0 : r_g_idx + SW'(1);
        w_state_nxt = S_ARB;
      end
      S_FLUSH: begin
        if (w_fifo_count == '0) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_mask   <= '0;
      r_primed <= '0;
      r_issued <= '0;
      r_rr     <= '0;
      r_g_idx  <= '0;
      r_q_cnt  <= '0;
      r_pend   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mask   <= w_mask_nxt;
      r_primed <= w_primed_nxt;
      r_issued <= w_issued_nxt;
      r_rr     <= w_rr_nxt;
      r_g_idx  <= w_g_idx_nxt;
      r_q_cnt  <= w_q_cnt_nxt;
      r_pend   <= w_pend_nxt;
    end
  end

  // Returning flits are always from the granted source, including the DRAIN trailer.
  assign w_push      = src_valid[r_g_idx];
  assign w_push_data = {r_g_idx, src_data[32'(r_g_idx) * FLIT_W +: FLIT_W]};
  assign w_pop       = w_fifo_valid & out_ready;

  inj_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign src_enable = w_enable;
  assign out_flit   = w_head[FLIT_W-1:0];
  assign out_src    = w_head[EW-1:FLIT_W];
  assign out_valid  = w_fifo_valid;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign all_done   = (r_state == S_DONE);

`ifdef INJ_SCHED_CHECK_EN
  logic [N_SRC-1:0] r_en_q;
  logic [N_SRC-1:0] r_pend_q;
  logic             r_err;

  // Flag stray flits and primed enables that returned nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_q   <= '0;
      r_pend_q <= '0;
      r_err    <= 1'b0;
    end else begin
      r_en_q   <= w_enable;
      r_pend_q <= w_enable & r_primed;
      if ((|(src_valid & ~r_en_q)) || (|(r_pend_q & ~src_valid))) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inj_sched.sv
// Bench for inj_sched: ROM injector models plus a round-robin quantum model
// that predicts the full flit order from the masked sources.
module tb_inj_sched;

  localparam int N_SRC   = 4;
  localparam int FLIT_W  = 20;
  localparam int QUANTUM = 4;
  localparam int WORDS   = 30;

  typedef struct packed {
    logic [1:0]        src;
    logic [FLIT_W-1:0] data;
  } flit_t;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [N_SRC-1:0]        src_mask;
  logic [N_SRC-1:0]        src_enable;
  logic [N_SRC*FLIT_W-1:0] src_data;
  logic [N_SRC-1:0]        src_valid;
  logic [FLIT_W-1:0]       out_flit;
  logic [1:0]              out_src;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    all_done;
  logic                    err;

  logic [FLIT_W-1:0]       rom [N_SRC][WORDS];
  logic [N_SRC-1:0]        inj_armed;
  logic [N_SRC-1:0]        inj_valid;
  logic [N_SRC-1:0]        force_valid;
  logic [N_SRC*FLIT_W-1:0] inj_data;
  int                      inj_ptr [N_SRC];

  flit_t exp_q [$];
  int    ntests;
  int    nfail;
  int    first_en;
  int    first_ov;

  inj_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_mask   (src_mask),
    .src_enable (src_enable),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .out_flit   (out_flit),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .all_done   (all_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM injector: first enable arms, later enables return one word next cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      inj_armed <= '0;
      inj_valid <= '0;
      inj_data  <= '0;
      for (int i = 0; i < N_SRC; i++) inj_ptr[i] <= 0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        inj_valid[i] <= 1'b0;
        if (src_enable[i]) begin
          if (!inj_armed[i]) begin
            inj_armed[i] <= 1'b1;
          end else begin
            inj_valid[i] <= 1'b1;
            inj_data[i*FLIT_W +: FLIT_W] <= (inj_ptr[i] < WORDS) ? rom[i][inj_ptr[i]] : '0;
            inj_ptr[i] <= inj_ptr[i] + 1;
          end
        end
      end
    end
  end

  assign src_valid = inj_valid | force_valid;
  assign src_data  = inj_data;

  task automatic fill_rom();
    for (int s = 0; s < N_SRC; s++)
      for (int w = 0; w < WORDS; w++) rom[s][w] = FLIT_W'($urandom);
  endtask

  // Expected order: repeated passes over masked sources, QUANTUM words each.
  task automatic build_exp(input logic [N_SRC-1:0] mask);
    int  cnt [N_SRC];
    int  n;
    bit  more;
    exp_q.delete();
    for (int s = 0; s < N_SRC; s++) cnt[s] = 0;
    do begin
      more = 1'b0;
      for (int s = 0; s < N_SRC; s++) begin
        if (mask[s] && cnt[s] < WORDS) begin
          n = (WORDS - cnt[s] < QUANTUM) ? WORDS - cnt[s] : QUANTUM;
          for (int k = 0; k < n; k++) exp_q.push_back({2'(s), rom[s][cnt[s] + k]});
          cnt[s] += n;
          more = 1'b1;
        end
      end
    end while (more);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_seq(input logic [N_SRC-1:0] mask, input int ready_pct,
                         input int stall_at, input int abort_at, input string tag);
    int    cyc = 0;
    int    pops = 0;
    int    viol = 0;
    int    stall_left = 0;
    bit    stall_done = 1'b0;
    bit    aborted = 1'b0;
    flit_t exp;
    flit_t got;
    build_exp(mask);
    first_en = -1;
    first_ov = -1;
    @(negedge clk);
    src_mask = mask;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!all_done && cyc < 4000) begin
      if (!stall_done && stall_at >= 0 && pops >= stall_at) begin
        stall_left = 12;
        stall_done = 1'b1;
      end
      out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
      #1;
      if ((src_enable & ~mask) != '0 || (src_enable & 4'(src_enable - 4'd1)) != '0) viol++;
      if (src_enable != '0 && first_en < 0) first_en = cyc;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (stall_left == 1) begin
        ntests++;
        if (dut.w_fifo_count !== 3'd4 || src_enable !== 4'b0 || out_valid !== 1'b1) begin
          nfail++;
          $display("FAIL %s stall: fifo_count=%0d src_enable=%b out_valid=%b, want 4/0000/1",
                   tag, dut.w_fifo_count, src_enable, out_valid);
        end
      end
      if (stall_left > 0) stall_left--;
      if (out_valid && out_ready) begin
        got = {out_src, out_flit};
        ntests++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL %s extra flit %0d: got src=%0d data=%h, want none", tag, pops, got.src, got.data);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            nfail++;
            $display("FAIL %s flit %0d: got src=%0d data=%h, want src=%0d data=%h",
                     tag, pops, got.src, got.data, exp.src, exp.data);
          end
        end
        pops++;
      end
      if (abort_at >= 0 && pops == abort_at) begin
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    if (aborted) return;
    #1;
    ntests++;
    if (all_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL %s end: all_done=%b busy=%b out_valid=%b after %0d cycles, want 1/0/0",
               tag, all_done, busy, out_valid, cyc);
    end
    ntests++;
    if (exp_q.size() != 0 || viol != 0) begin
      nfail++;
      $display("FAIL %s totals: %0d flits missing, %0d bad enable cycles, want 0/0",
               tag, exp_q.size(), viol);
    end
    ntests++;
    if (err !== 1'b0) begin
      nfail++;
      $display("FAIL %s err: got %b, want 0", tag, err);
    end
  endtask

  task automatic check_zero(input string tag);
    ntests++;
    if (src_enable !== '0 || out_flit !== '0 || out_src !== '0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || all_done !== 1'b0 || err !== 1'b0) begin
      nfail++;
      $display("FAIL %s outputs: en=%b flit=%h src=%0d v=%b busy=%b done=%b err=%b, want all 0",
               tag, src_enable, out_flit, out_src, out_valid, busy, all_done, err);
    end
  endtask

  task automatic test_reset();
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_uniform();
    do_reset();
    run_seq(4'hF, 100, -1, -1, "uniform");
    ntests++;
    if (first_ov - first_en !== 3) begin
      nfail++;
      $display("FAIL uniform latency: got %0d cycles, want 3", first_ov - first_en);
    end
  endtask

  task automatic test_mask();
    do_reset();
    run_seq(4'b0101, 100, -1, -1, "mask");
  endtask

  task automatic test_backpressure();
    do_reset();
    run_seq(4'hF, 100, 20, -1, "backpressure");
  endtask

  task automatic test_random();
    logic [N_SRC-1:0] m;
    for (int r = 0; r < 2; r++) begin
      fill_rom();
      m = 4'($urandom_range(1, 15));
      do_reset();
      run_seq(m, 60, -1, -1, "random");
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_seq(4'hF, 100, -1, 37, "rmid");
    ntests++;
    if (busy !== 1'b1) begin
      nfail++;
      $display("FAIL rmid busy before reset: got %b, want 1", busy);
    end
    #2;
    rst = 1'b0;
    #1;
    check_zero("rmid async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_seq(4'hF, 100, -1, -1, "rmid rerun");
  endtask

  task automatic test_empty_mask();
    int hit = -1;
    logic [N_SRC-1:0] en_seen = '0;
    do_reset();
    @(negedge clk);
    src_mask = '0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (all_done && hit < 0) hit = c;
      en_seen |= src_enable;
      @(negedge clk);
    end
    ntests++;
    if (hit < 0 || hit > 1 || en_seen !== '0) begin
      nfail++;
      $display("FAIL empty mask: all_done at cycle %0d, enables seen %b, want <=1 and 0000", hit, en_seen);
    end
  endtask

`ifdef INJ_SCHED_CHECK_EN
  task automatic test_err();
    int c = 0;
    do_reset();
    @(negedge clk);
    src_mask = 4'hF;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!src_enable[1] && c < 500) begin
      @(negedge clk);
      #1;
      c++;
    end
    force_valid = 4'b1000;
    @(negedge clk);
    force_valid = 4'b0000;
    #1;
    ntests++;
    if (err !== 1'b1 || c >= 500) begin
      nfail++;
      $display("FAIL err set: got %b (wait %0d cycles), want 1", err, c);
    end
    repeat (10) @(negedge clk);
    #1;
    ntests++;
    if (err !== 1'b1) begin
      nfail++;
      $display("FAIL err sticky: got %b, want 1", err);
    end
    do_reset();
    #1;
    ntests++;
    if (err !== 1'b0) begin
      nfail++;
      $display("FAIL err cleared: got %b, want 0", err);
    end
  endtask
`endif

  initial begin
    ntests      = 0;
    nfail       = 0;
    rst         = 1'b1;
    start       = 1'b0;
    src_mask    = '0;
    out_ready   = 1'b1;
    force_valid = '0;
    fill_rom();
    #3 rst = 1'b0;
    test_reset();
    test_uniform();
    test_mask();
    test_backpressure();
    test_reset_mid();
    test_empty_mask();
    test_random();
`ifdef INJ_SCHED_CHECK_EN
    test_err();
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/inj_sched.md
Name: inj_sched

Overview:
- Injection scheduler for one router local port, fed by N_SRC ROM-backed traffic injectors.
- Each injector has a 1-bit `enable` input, a 20-bit `dataout` and `out_valid`. When enabled, it streams one flit per cycle with 1-cycle latency.
- The block round-robins `enable` among the injectors in fixed-size quanta and merges the returned flits into a skid FIFO.
- It presents the flits downstream with a valid/ready handshake, so nothing is lost under backpressure.

Parameters:
- N_SRC, 4, number of injectors.
- FLIT_W, 20, flit width.
- QUANTUM, 4, max words requested per grant.
- WORDS_PER_SRC, 30, words each injector holds; the source is exhausted after this many.
- FIFO_DEPTH, 4, skid FIFO entries (≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; begins a run when in IDLE.
- src_mask  in  N_SRC  1 = source participates; sampled when start is accepted.
- src_enable  out  N_SRC  per-injector enable; at most one bit high.
- src_data  in  N_SRC*FLIT_W  injector dataout, source i at [i*FLIT_W +: FLIT_W].
- src_valid  in  N_SRC  injector out_valid.
- out_flit  out  FLIT_W  FIFO head flit.
- out_src  out  clog2(N_SRC)  originating source of out_flit.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts; pop on out_valid && out_ready.
- busy  out  1  run in progress (state ≠ IDLE/DONE).
- all_done  out  1  high in DONE (every source exhausted, FIFO empty).
- err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (async, rst=0): all outputs 0; state IDLE; FIFO empty; all primed/issued counters 0; rr pointer 0. A reset mid-run discards FIFO contents and counters. Injectors share rst, so they restart coherently.
- Injector model, relied upon:
  - The first enable cycle to a fresh injector only arms it; no flit follows.
  - Each later enable cycle yields exactly one flit with src_valid on the next cycle.
  - Dropping enable stops the flits on the next cycle.
- Per-source state:
  - primed bit.
  - issued count, width clog2(WORDS_PER_SRC+1).
  - exhausted = ~mask_bit || issued == WORDS_PER_SRC.
- IDLE:
  - On start, latch src_mask and go to ARB.
  - If every masked source is already exhausted, go to DONE directly.
- ARB (1 cycle):
  - Pick the first non-exhausted source at or after the rr pointer, wrapping around.
  - Load g_idx and q_cnt = 0; go to GRANT.
  - If no source is eligible, go to FLUSH.
- GRANT, per cycle:
  - src_enable[g_idx] = 1 iff (fifo_count + pend) < FIFO_DEPTH.
  - pend = 1 if enable was issued last cycle to a primed source, else 0.
  - On an issued enable: if not primed, set primed and leave q_cnt unchanged; if primed, increment issued and q_cnt.
  - Leave GRANT when q_cnt reaches QUANTUM or the source becomes exhausted, with the last word issued that same cycle. Then enable drops and the state goes to DRAIN.
- DRAIN (1 cycle):
  - Captures the trailing flit.
  - Set rr pointer = g_idx+1 mod N_SRC; go to ARB.
- FLIT capture, every cycle: if src_valid[g_idx], push {g_idx, src_data slice} into the FIFO. No overflow is possible by construction.
- FLUSH: wait for the FIFO to empty, then go to DONE.
- DONE: all_done = 1; start returns the block to IDLE-equivalent processing.
- FIFO simultaneous push and pop: fifo_count unchanged; full-with-pop still accepts the push.
- Latency: 2 cycles from the first primed enable to out_valid.

Optional Feature:
- Macro: INJ_SCHED_CHECK_EN.
- When defined, err is set (sticky until reset) if either:
  - any src_valid bit is seen for a source not enabled in the previous cycle; or
  - a primed enable is not followed by src_valid of that source.
- When not defined, err is tied 0 and the checker logic is absent.

Decomposition:
- Package inj_pkg:
  - FLIT_W.
  - State enum: IDLE, ARB, GRANT, DRAIN, FLUSH, DONE.
  - Source index width function (clog2).
  - Flit field positions: dest_local [1:0], payload [19:4].
- Sub-module inj_skid_fifo: parameterised depth and width, count output, push/pop. The scheduler FSM stays in inj_sched.

Test Plan:
- Uniform run: 4 ROM injectors, mask=4'hF, out_ready=1, start pulse.
  - 120 flits in order: src0 words 0-3, src1 0-3, src2 0-3, src3 0-3, src0 4-7, …
  - Each source's 8th grant carries words 28-29 (2 words).
  - all_done 1 after the last pop; first out_valid 3 cycles after the arming enable.
- Mask: mask=4'b0101.
  - Only src0 and src2 flits, interleaved in quanta of 4 (60 total).
  - src_enable[1] and src_enable[3] never high.
- Backpressure: out_ready=0 for 12 cycles mid-run.
  - fifo_count saturates at 4 and src_enable drops.
  - After release, the sequence is intact with no duplicates or gaps.
- Reset mid-GRANT: rst low for 2 cycles at flit 37.
  - All outputs 0 immediately (async).
  - New start reproduces the uniform sequence from flit 0.
- Empty mask: start with mask=0 → all_done=1 within 2 cycles, no enables issued.
- With INJ_SCHED_CHECK_EN: force src_valid[3] while src1 is granted → err=1 and stays 1 until reset.
